// File: rtl/nios_2_key_pio_in.sv
// Avalon-MM PIO input port for KEY/SW: 2-FF sync, per-bit debounce, sticky edge capture
// and a maskable level interrupt, laid out like the standard PIO so the HAL drivers apply.
module nios_2_key_pio_in #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter int unsigned COUNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam bit                 FILTER_EN = (DEBOUNCE_CYCLES > 32'd1);
  localparam int unsigned        DEB_LAST  = FILTER_EN ? (DEBOUNCE_CYCLES - 32'd1) : 32'd0;
  localparam logic [COUNT_W-1:0] CNT_LAST  = COUNT_W'(DEB_LAST);
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(32'd1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0]   s1_q;
  logic [WIDTH-1:0]   s2_q;
  logic [WIDTH-1:0]   deb_q;
  logic [WIDTH-1:0]   deb_d;
  logic [WIDTH-1:0]   prev_q;
  logic [COUNT_W-1:0] cnt_q [WIDTH];
  logic [COUNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0]   irq_mask_q;
  logic [WIDTH-1:0]   irq_mask_d;
  logic [WIDTH-1:0]   edge_capture_q;
  logic [WIDTH-1:0]   edge_capture_d;
  logic [31:0]        readdata_q;
  logic [31:0]        readdata_d;

  logic               wr_en_s;
  logic               rd_en_s;
  logic [WIDTH-1:0]   edge_ev_s;
  logic [WIDTH-1:0]   w1c_s;
  logic [31:0]        rd_word_s;
  logic               wdata_unused_s;

  assign wr_en_s        = chipselect & ~write_n;
  assign rd_en_s        = chipselect & ~read_n;
  assign wdata_unused_s = &{1'b0, writedata};

  // Two-stage synchronizer; the only consumer of the raw pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  end

  // A bit is accepted only after the synchronized level differs from deb for a full window;
  // any return to the accepted level restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (!FILTER_EN) begin
        deb_d[i] = s2_q[i];
      end else if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Edge qualifier chosen at elaboration time.
  always_comb begin
    case (EDGE_TYPE)
      32'd0:   edge_ev_s = deb_q & ~prev_q;
      32'd1:   edge_ev_s = ~deb_q & prev_q;
      default: edge_ev_s = deb_q ^ prev_q;
    endcase
  end

  // Mask write and write-1-to-clear; a fresh event overrides a clear on the same bit.
  always_comb begin
    irq_mask_d = irq_mask_q;
    w1c_s      = '0;
    if (wr_en_s && (address == ADDR_MASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end else begin
      irq_mask_d = irq_mask_q;
    end
    if (wr_en_s && (address == ADDR_EDGE)) begin
      w1c_s = writedata[WIDTH-1:0];
    end else begin
      w1c_s = '0;
    end
    edge_capture_d = (edge_capture_q & ~w1c_s) | edge_ev_s;
  end

  // Read mux; readdata holds its last value between reads.
  always_comb begin
    rd_word_s = '0;
    case (address)
      ADDR_DATA: rd_word_s[WIDTH-1:0] = deb_q;
      ADDR_RSVD: rd_word_s            = '0;
      ADDR_MASK: rd_word_s[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE: rd_word_s[WIDTH-1:0] = edge_capture_q;
      default:   rd_word_s            = '0;
    endcase
    if (rd_en_s) begin
      readdata_d = rd_word_s;
    end else begin
      readdata_d = readdata_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q          <= '0;
      prev_q         <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata_q     <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q          <= deb_d;
      prev_q         <= deb_q;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: doc/nios_2_key_pio_in.md
Name: nios_2_key_pio_in

Overview:
Avalon-MM slave input port that lets the Nios II read the board pushbuttons and switches (KEY/SW), complementing the LED output port. It synchronizes and debounces the external pins and latches edges into a sticky capture register. It raises a maskable level interrupt to the CPU. Register map is compatible with the standard PIO layout, so the existing HAL drivers work unchanged.

Parameters:
WIDTH, 4, number of input pins (1..32)
DEBOUNCE_CYCLES, 50000, clocks a synchronized bit must stay stable before it is accepted (1 ms at 50 MHz); 0 or 1 disables filtering
EDGE_TYPE, 1, edge captured: 0 rising, 1 falling, 2 any
COUNT_W, 16, debounce counter width; must satisfy 2^COUNT_W > DEBOUNCE_CYCLES

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  2  register select (word address)
chipselect  in  1  slave select
read_n  in  1  active-low read strobe
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data, readLatency 1
in_port  in  WIDTH  raw asynchronous pins
irq  out  1  level interrupt to CPU

Behaviour:
- Reset: clk and reset_n as decided above. Asynchronous, active-low reset clears all registers to 0: sync stages, debounced value, previous value, debounce counters, irq_mask, edge_capture, readdata. irq = 0.
- Sync: 2-FF chain per bit, in_port -> s1 -> s2. No other logic reads in_port.
- Debounce, one counter per bit:
  - s2 == deb: counter <= 0.
  - s2 != deb and counter == DEBOUNCE_CYCLES-1: deb <= s2, counter <= 0.
  - Otherwise: counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES clocks restarts the count and never reaches deb.
  - DEBOUNCE_CYCLES <= 1: deb <= s2 every clock.
- Latency: a pin change set up before clk edge k has the following timing:
  - deb updates at edge k+1+max(DEBOUNCE_CYCLES,1).
  - edge_capture bit sets one edge later.
  - irq is high after that edge if the bit is masked in.
- Edge detect: prev <= deb every clock.
  - Rising event = deb & ~prev.
  - Falling event = ~deb & prev.
  - Any = either.
  - An event sets edge_capture[i] (sticky).
  - A pin held high through reset produces a rising event after release. irq_mask resets to 0, so no interrupt results. Software clears edge_capture before unmasking.
- Register map (address):
  - 0 DATA: read = deb, zero-extended. Writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK: R/W, bits [WIDTH-1:0] used, upper bits read 0.
  - 3 EDGE_CAPTURE: read = edge_capture. Write-1-to-clear per bit; 0 bits are unaffected.
- Write: occurs on the clock edge where chipselect=1 and write_n=0. No wait states.
- Read: on the edge where chipselect=1 and read_n=0, readdata <= selected register. Readdata is valid the following cycle and holds until the next read. Reads have no side effects; a read does not clear capture.
- Simultaneous W1C and new event on the same bit in the same cycle: the event wins and the bit stays 1.
- irq = |(edge_capture & irq_mask), combinational from registers, so there is no extra latency. A mask write takes effect the cycle after the write edge.
- Reset asserted mid-debounce or mid-read: everything returns to reset values immediately. No partial state survives.
- chipselect=1 with both read_n and write_n high: no effect.

Test Plan:
1. Reset with in_port=4'hF, DEBOUNCE_CYCLES=4, EDGE_TYPE=1 -> after release, DATA reads 4'hF by edge 6. EDGE_CAPTURE = 0 because only a rising event occurred. irq=0.
2. Debounce filter, DEBOUNCE_CYCLES=4: bit0 goes 1->0 for 3 clocks then back to 1 -> DATA stays 4'hF and EDGE_CAPTURE stays 0. Holding 0 for 6 clocks -> DATA reads 4'hE and EDGE_CAPTURE reads 4'h1.
3. Interrupt: write IRQ_MASK=4'h1 while EDGE_CAPTURE=4'h1 -> irq=1 the next cycle. Write 4'h1 to addr 3 -> irq=0 the next cycle and EDGE_CAPTURE reads 0.
4. Collision: a W1C of bit2 lands on the same edge that bit2's falling event sets it -> EDGE_CAPTURE[2] reads 1 and irq stays asserted if masked.
5. Bus checks:
   - Read addr 1 -> 0.
   - Write 32'hFFFFFFFF to addr 0 -> DATA unchanged.
   - IRQ_MASK write 32'hFFFFFFFF -> reads 32'h0000000F.
   - Each read returns data exactly one cycle after the strobe.
6. EDGE_TYPE=2 with DEBOUNCE_CYCLES=0: bit3 pulses 0->1->0 (each level held 3 clocks) -> two events, bit3 captured on the rising one. Cleared bit3 re-sets on the falling one, 3 clocks after the level change at the pin.
